// File: rtl/h75_pkg.sv
// Shared constants and types for the HUB75 framebuffer write path.
package h75_pkg;

  localparam int unsigned H75_ADDR_W   = 14;
  localparam int unsigned H75_DATA_W   = 16;
  localparam int unsigned H75_FB_WORDS = 16384;

  typedef logic h75_page_t;

  typedef enum logic {
    IDLE,
    FILL
  } h75_fill_state_t;

endpackage

// File: rtl/h75_rr_arb2.sv
// Two-requester round-robin arbiter; req[0] is the CPU, req[1] the pixel stream.
module h75_rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_q)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else if (gnt[0]) begin
      last_q <= 1'b0;
    end else if (gnt[1]) begin
      last_q <= 1'b1;
    end
  end

endmodule

// File: rtl/h75_fb_write_scheduler.sv
// Owns the framebuffer write port: arbitrates CPU/stream/fill writes into the back page
// and swaps the displayed page on frame boundaries.
module h75_fb_write_scheduler
  import h75_pkg::*;
#(
  parameter int unsigned ADDR_W   = H75_ADDR_W,
  parameter int unsigned DATA_W   = H75_DATA_W,
  parameter int unsigned FB_WORDS = H75_FB_WORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              strm_valid,
  input  logic [ADDR_W-1:0] strm_addr,
  input  logic [DATA_W-1:0] strm_data,
  output logic              strm_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  input  logic              swap_req,
  input  logic              frame_sync,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              disp_page,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(FB_WORDS - 1);

  h75_fill_state_t   fill_state_q, fill_state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              fill_active;
  logic              fill_last;

  h75_page_t         disp_page_q;
  logic              swap_pending_q;
  logic              swap_done_q;
  logic              sync_q;
  logic              frame_edge;
  logic              swap_fire;

  logic [1:0]        gnt;
  logic              arb_en;

  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] wr_word;
  logic [DATA_W-1:0] wr_data_d;
  logic [ADDR_W:0]   wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign fill_active = (fill_state_q == FILL);
  assign fill_last   = fill_active && (fill_cnt_q == LastWord);
  assign arb_en      = !fill_active;

  h75_rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     (arb_en),
    .req    ({strm_valid, cpu_req}),
    .gnt    (gnt)
  );

  always_comb begin
    fill_state_d = fill_state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_val_d   = fill_val_q;
    unique case (fill_state_q)
      IDLE: begin
        if (fill_start) begin
          fill_state_d = FILL;
          fill_cnt_d   = '0;
          fill_val_d   = fill_value;
        end
      end
      FILL: begin
        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        if (fill_last) begin
          fill_state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    wr_en_d   = fill_active || (|gnt);
    wr_word   = strm_addr;
    wr_data_d = strm_data;
    if (fill_active) begin
      wr_word   = fill_cnt_q;
      wr_data_d = fill_val_q;
    end else if (gnt[0]) begin
      wr_word   = cpu_addr;
      wr_data_d = cpu_data;
    end
  end

  // Fill owns the page during its run, so a boundary seen mid-fill is deferred.
  assign frame_edge = frame_sync && !sync_q;
  assign swap_fire  = frame_edge && (swap_pending_q || swap_req) && !fill_active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_state_q   <= IDLE;
      fill_cnt_q     <= '0;
      fill_val_q     <= '0;
      disp_page_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      sync_q         <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      fill_state_q <= fill_state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_val_q   <= fill_val_d;
      sync_q       <= frame_sync;
      swap_done_q  <= swap_fire;
      if (swap_fire) begin
        disp_page_q    <= ~disp_page_q;
        swap_pending_q <= 1'b0;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end
      wr_en_q <= wr_en_d;
      // Back page is taken from the pre-swap display page in the grant cycle.
      if (wr_en_d) begin
        wr_addr_q <= {~disp_page_q, wr_word};
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign cpu_ack      = gnt[0];
  assign strm_ready   = gnt[1];
  assign fill_busy    = fill_active;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign disp_page    = disp_page_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_h75_fb_write_scheduler.sv
// Directed self-checking bench for h75_fb_write_scheduler.
module tb_h75_fb_write_scheduler;

  logic        clk;
  logic        resetn;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ack;
  logic        strm_valid;
  logic [13:0] strm_addr;
  logic [15:0] strm_data;
  logic        strm_ready;
  logic        fill_start;
  logic [15:0] fill_value;
  logic        fill_busy;
  logic        swap_req;
  logic        frame_sync;
  logic        swap_pending;
  logic        swap_done;
  logic        disp_page;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;

  int n_cmp;
  int n_bad;

  h75_fb_write_scheduler dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_ack      (cpu_ack),
    .strm_valid   (strm_valid),
    .strm_addr    (strm_addr),
    .strm_data    (strm_data),
    .strm_ready   (strm_ready),
    .fill_start   (fill_start),
    .fill_value   (fill_value),
    .fill_busy    (fill_busy),
    .swap_req     (swap_req),
    .frame_sync   (frame_sync),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .disp_page    (disp_page),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cpu_data   = '0;
    strm_valid = 1'b0;
    strm_addr  = '0;
    strm_data  = '0;
    fill_start = 1'b0;
    fill_value = '0;
    swap_req   = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #3;
    n_cmp++;
    if ({wr_en, cpu_ack, strm_ready, fill_busy, swap_pending, swap_done, disp_page} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {wr_en, cpu_ack, strm_ready, fill_busy, swap_pending, swap_done, disp_page});
    end
    n_cmp++;
    if (wr_addr !== 15'h0 || wr_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_wr: got addr %h data %h want 0 0", wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_cpu_single();
    cpu_req  = 1'b1;
    cpu_addr = 14'h0010;
    cpu_data = 16'hABCD;
    #1;
    n_cmp++;
    if (cpu_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL cpu_ack: got %b want 1", cpu_ack);
    end
    step();
    cpu_req = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h4010 || wr_data !== 16'hABCD) begin
      n_bad++;
      $display("FAIL cpu_write: got en %b addr %h data %h want 1 4010 abcd", wr_en, wr_addr, wr_data);
    end
    #1;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_no_dup_ack: got %b want 0", cpu_ack);
    end
    step();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_single_pulse: got wr_en %b want 0", wr_en);
    end
  endtask

  task automatic test_round_robin();
    int c;
    int s;
    int n_writes;
    logic        exp_cpu;
    logic [14:0] exp_addr;
    logic [15:0] exp_data;
    do_reset();
    c = 0;
    s = 0;
    n_writes = 0;
    cpu_req    = 1'b1;
    cpu_addr   = 14'h0100;
    cpu_data   = 16'hC000;
    strm_valid = 1'b1;
    strm_addr  = 14'h0200;
    strm_data  = 16'h5000;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_cpu = (k % 2 == 0);
      n_cmp++;
      if (cpu_ack !== exp_cpu || strm_ready !== !exp_cpu) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got ack %b ready %b want %b %b", k, cpu_ack, strm_ready,
                 exp_cpu, !exp_cpu);
      end
      exp_addr = exp_cpu ? (15'h4100 + 15'(c)) : (15'h4200 + 15'(s));
      exp_data = exp_cpu ? (16'hC000 + 16'(c)) : (16'h5000 + 16'(s));
      step();
      if (wr_en === 1'b1) n_writes++;
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== exp_addr || wr_data !== exp_data) begin
        n_bad++;
        $display("FAIL rr_write%0d: got en %b addr %h data %h want 1 %h %h", k, wr_en, wr_addr,
                 wr_data, exp_addr, exp_data);
      end
      if (exp_cpu) begin
        c++;
        cpu_addr = 14'h0100 + 14'(c);
        cpu_data = 16'hC000 + 16'(c);
      end else begin
        s++;
        strm_addr = 14'h0200 + 14'(s);
        strm_data = 16'h5000 + 16'(s);
      end
    end
    cpu_req    = 1'b0;
    strm_valid = 1'b0;
    step();
    if (wr_en === 1'b1) n_writes++;
    n_cmp++;
    if (n_writes != 6) begin
      n_bad++;
      $display("FAIL rr_write_count: got %0d want 6", n_writes);
    end
  endtask

  task automatic test_fill();
    int busy_bad;
    int wr_bad;
    busy_bad = 0;
    wr_bad   = 0;
    fill_start = 1'b1;
    fill_value = 16'h0F0F;
    #1;
    n_cmp++;
    if (fill_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_busy_early: got %b want 0", fill_busy);
    end
    step();
    fill_start = 1'b0;
    fill_value = 16'hFFFF;
    cpu_req    = 1'b1;
    cpu_addr   = 14'h0033;
    cpu_data   = 16'h1234;
    strm_valid = 1'b1;
    strm_addr  = 14'h0044;
    strm_data  = 16'h4444;
    #1;
    for (int i = 0; i < 16384; i++) begin
      if (fill_busy !== 1'b1 || cpu_ack !== 1'b0 || strm_ready !== 1'b0) busy_bad++;
      step();
      if (wr_en !== 1'b1 || wr_addr !== (15'h4000 + 15'(i)) || wr_data !== 16'h0F0F) wr_bad++;
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_bad++;
      $display("FAIL fill_blocking: got %0d bad cycles want 0", busy_bad);
    end
    n_cmp++;
    if (wr_bad != 0) begin
      n_bad++;
      $display("FAIL fill_writes: got %0d bad writes want 0", wr_bad);
    end
    n_cmp++;
    if (fill_busy !== 1'b0 || cpu_ack !== 1'b1 || strm_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_end: got busy %b ack %b ready %b want 0 1 0", fill_busy, cpu_ack,
               strm_ready);
    end
    step();
    cpu_req = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h4033 || wr_data !== 16'h1234) begin
      n_bad++;
      $display("FAIL fill_stalled_cpu: got en %b addr %h data %h want 1 4033 1234", wr_en,
               wr_addr, wr_data);
    end
    #1;
    n_cmp++;
    if (strm_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_stalled_strm_ready: got %b want 1", strm_ready);
    end
    step();
    strm_valid = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h4044 || wr_data !== 16'h4444) begin
      n_bad++;
      $display("FAIL fill_stalled_strm: got en %b addr %h data %h want 1 4044 4444", wr_en,
               wr_addr, wr_data);
    end
    step();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_idle_after: got wr_en %b want 0", wr_en);
    end
  endtask

  task automatic test_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_cmp++;
    if (swap_pending !== 1'b1 || disp_page !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_pend: got pend %b page %b want 1 0", swap_pending, disp_page);
    end
    swap_req = 1'b1;
    step();
    swap_req   = 1'b0;
    frame_sync = 1'b1;
    step();
    n_cmp++;
    if (disp_page !== 1'b1 || swap_done !== 1'b1 || swap_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_apply: got page %b done %b pend %b want 1 1 0", disp_page, swap_done,
               swap_pending);
    end
    step();
    n_cmp++;
    if (disp_page !== 1'b1 || swap_done !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_done_pulse: got page %b done %b want 1 0", disp_page, swap_done);
    end
    frame_sync = 1'b0;
    step();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    n_cmp++;
    if (disp_page !== 1'b1 || swap_done !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_no_double: got page %b done %b want 1 0", disp_page, swap_done);
    end
    cpu_req  = 1'b1;
    cpu_addr = 14'h0005;
    cpu_data = 16'h0BEE;
    step();
    cpu_req = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h0005 || wr_data !== 16'h0BEE) begin
      n_bad++;
      $display("FAIL swap_new_back: got en %b addr %h data %h want 1 0005 0bee", wr_en, wr_addr,
               wr_data);
    end
    step();
  endtask

  task automatic test_swap_during_fill();
    int page_bad;
    page_bad = 0;
    fill_start = 1'b1;
    fill_value = 16'hA5A5;
    step();
    fill_start = 1'b0;
    swap_req   = 1'b1;
    step();
    swap_req = 1'b0;
    n_cmp++;
    if (swap_pending !== 1'b1 || fill_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sdf_pend: got pend %b busy %b want 1 1", swap_pending, fill_busy);
    end
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    n_cmp++;
    if (disp_page !== 1'b1 || swap_done !== 1'b0 || swap_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL sdf_deferred: got page %b done %b pend %b want 1 0 1", disp_page, swap_done,
               swap_pending);
    end
    for (int t = 0; t < 20000 && fill_busy === 1'b1; t++) begin
      step();
      if (wr_en === 1'b1 && wr_addr[14] !== 1'b0) page_bad++;
    end
    n_cmp++;
    if (fill_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sdf_fill_timeout: got busy %b want 0", fill_busy);
    end
    n_cmp++;
    if (page_bad != 0) begin
      n_bad++;
      $display("FAIL sdf_fill_page: got %0d writes to page 1 want 0", page_bad);
    end
    n_cmp++;
    if (disp_page !== 1'b1 || swap_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL sdf_hold: got page %b pend %b want 1 1", disp_page, swap_pending);
    end
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    n_cmp++;
    if (disp_page !== 1'b0 || swap_done !== 1'b1 || swap_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL sdf_apply: got page %b done %b pend %b want 0 1 0", disp_page, swap_done,
               swap_pending);
    end
    step();
  endtask

  task automatic test_reset_mid_fill();
    int n_wr;
    int n_done;
    n_wr   = 0;
    n_done = 0;
    swap_req   = 1'b1;
    frame_sync = 1'b1;
    step();
    swap_req   = 1'b0;
    frame_sync = 1'b0;
    n_cmp++;
    if (disp_page !== 1'b1 || swap_done !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_swap: got page %b done %b want 1 1", disp_page, swap_done);
    end
    fill_start = 1'b1;
    fill_value = 16'h7777;
    step();
    fill_start = 1'b0;
    swap_req   = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (wr_en !== 1'b1 || fill_busy !== 1'b1 || swap_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_state: got en %b busy %b pend %b want 1 1 1", wr_en, fill_busy,
               swap_pending);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, fill_busy, swap_pending, swap_done, disp_page} !== 5'b0 ||
        wr_addr !== 15'h0 || wr_data !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_async: got flags %b addr %h data %h want 00000 0 0",
               {wr_en, fill_busy, swap_pending, swap_done, disp_page}, wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int t = 0; t < 20; t++) begin
      frame_sync = (t == 5);
      step();
      if (wr_en === 1'b1) n_wr++;
      if (swap_done === 1'b1 || disp_page !== 1'b0) n_done++;
    end
    frame_sync = 1'b0;
    n_cmp++;
    if (n_wr != 0) begin
      n_bad++;
      $display("FAIL rst_no_fill: got %0d writes want 0", n_wr);
    end
    n_cmp++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL rst_no_swap: got %0d swap cycles want 0", n_done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_cpu_single();
    test_round_robin();
    test_fill();
    test_swap();
    test_swap_during_fill();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
